// File: rtl/dff_to_sr_pkg.sv
// Shared types and default widths for the D-to-SR storage bank.
package dff_to_sr_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_ERR_CNT_W = 8;
  localparam int unsigned MODE_W            = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_D  = 2'b11
  } mode_e;

endpackage : dff_to_sr_pkg

// File: rtl/dff_to_sr_bank_if.sv
// Control/data bundle between a driver and the dff_to_sr_bank storage bank.
interface dff_to_sr_bank_if
  import dff_to_sr_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ERR_CNT_W = DEFAULT_ERR_CNT_W
);

  logic                 en;
  logic                 clr;
  logic [MODE_W-1:0]    mode;
  logic [WIDTH-1:0]     S;
  logic [WIDTH-1:0]     R;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     Qb;
  logic                 illegal;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output en, clr, mode, S, R,
    input  Q, Qb, illegal, err_count
  );

  modport slave (
    input  en, clr, mode, S, R,
    output Q, Qb, illegal, err_count
  );

endinterface : dff_to_sr_bank_if

// File: rtl/d2sr_bit_cell.sv
// One storage bit: a D flop behind a next-state mux giving SR/JK/T/D behaviour.
// SR_SET_DOMINANT_EN: when defined, S=R=1 in SR mode sets the bit instead of holding.
module d2sr_bit_cell
  import dff_to_sr_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  mode_e mode,
  input  logic  s,
  input  logic  r,
  output logic  q,
  output logic  illegal_hit_c
);

  logic q_q;
  logic q_d;

  // Next-state mux: clear beats enable, enable gates the mode behaviour.
  always_comb begin
    q_d           = q_q;
    illegal_hit_c = 1'b0;
    if (clr) begin
      q_d = 1'b0;
    end else if (en) begin
      unique case (mode)
        MODE_SR: begin
          unique case ({s, r})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11: begin
              illegal_hit_c = 1'b1;
`ifdef SR_SET_DOMINANT_EN
              q_d = 1'b1;
`else
              q_d = q_q;
`endif
            end
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          unique case ({s, r})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        MODE_T:  q_d = s ? ~q_q : q_q;
        MODE_D:  q_d = s;
        default: q_d = q_q;
      endcase
    end
  end

  // Storage flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : d2sr_bit_cell

// File: rtl/dff_to_sr_bank.sv
// Bank of D flops presented as SR/JK/T/D storage with illegal-input flag
// and a saturating illegal-edge counter.
// SR_SET_DOMINANT_EN: when defined, S=R=1 in SR mode sets the bit (see d2sr_bit_cell).
module dff_to_sr_bank
  import dff_to_sr_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ERR_CNT_W = DEFAULT_ERR_CNT_W
)(
  input  logic              clk,
  input  logic              rst_n,
  dff_to_sr_bank_if.slave   bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  mode_e                mode;
  logic [WIDTH-1:0]     q_w;
  logic [WIDTH-1:0]     hit_w;
  logic                 any_hit_c;
  logic                 illegal_q;
  logic                 illegal_d;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;

  assign mode = mode_e'(bus.mode);

  // One cell per storage bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    d2sr_bit_cell u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (bus.en),
      .clr           (bus.clr),
      .mode          (mode),
      .s             (bus.S[i]),
      .r             (bus.R[i]),
      .q             (q_w[i]),
      .illegal_hit_c (hit_w[i])
    );
  end

  // Cells only report hits on enabled, non-cleared SR edges.
  assign any_hit_c = |hit_w;

  // Flag and counter next state: clear wins, otherwise count each illegal edge once.
  always_comb begin
    illegal_d   = 1'b0;
    err_count_d = err_count_q;
    if (bus.clr) begin
      err_count_d = '0;
    end else if (any_hit_c) begin
      illegal_d = 1'b1;
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  // Flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      illegal_q   <= illegal_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.Q         = q_w;
  assign bus.Qb        = ~q_w;
  assign bus.illegal   = illegal_q;
  assign bus.err_count = err_count_q;

endmodule : dff_to_sr_bank

// File: tb/tb_dff_to_sr_bank.sv
// Directed bench for dff_to_sr_bank: default-width instance plus a 2-bit-counter
// instance sharing the same stimulus for saturation.
module tb_dff_to_sr_bank;
  import dff_to_sr_pkg::*;

`ifdef SR_SET_DOMINANT_EN
  localparam bit SET_DOM = 1'b1;
`else
  localparam bit SET_DOM = 1'b0;
`endif

  logic clk;
  logic rst_n;

  dff_to_sr_bank_if #(.WIDTH(8), .ERR_CNT_W(8)) bus_a ();
  dff_to_sr_bank_if #(.WIDTH(8), .ERR_CNT_W(2)) bus_b ();

  dff_to_sr_bank #(.WIDTH(8), .ERR_CNT_W(8)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a.slave)
  );

  dff_to_sr_bank #(.WIDTH(8), .ERR_CNT_W(2)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b.slave)
  );

  assign bus_b.en   = bus_a.en;
  assign bus_b.clr  = bus_a.clr;
  assign bus_b.mode = bus_a.mode;
  assign bus_b.S    = bus_a.S;
  assign bus_b.R    = bus_a.R;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] exp_q;
    logic       exp_ill;
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input string name, input logic en, input logic clr,
                     input logic [1:0] mode, input logic [7:0] s, input logic [7:0] r,
                     input logic [7:0] q, input logic ill, input logic [7:0] cnt,
                     input logic [1:0] cnt2);
    vec_t v;
    v.name = name; v.en = en; v.clr = clr; v.mode = mode; v.s = s; v.r = r;
    v.exp_q = q; v.exp_ill = ill; v.exp_cnt = cnt; v.exp_cnt2 = cnt2;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [7:0] q, input logic ill,
                             input logic [7:0] cnt, input logic [1:0] cnt2);
    chk({name, ".Q"},       bus_a.Q, q);
    chk({name, ".Qb"},      bus_a.Qb, ~q);
    chk({name, ".illegal"}, 8'(bus_a.illegal), 8'(ill));
    chk({name, ".err_cnt"}, bus_a.err_count, cnt);
    chk({name, ".sat_cnt"}, 8'(bus_b.err_count), 8'(cnt2));
    chk({name, ".sat_Q"},   bus_b.Q, q);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Expected values hand-computed; set-dominant variant differs only on S=R=1 SR edges.
    add("sr_set",     1, 0, 2'b00, 8'h0F, 8'h00, 8'h0F, 0, 8'd0, 2'd0);
    add("sr_reset",   1, 0, 2'b00, 8'h00, 8'h03, 8'h0C, 0, 8'd0, 2'd0);
    add("sr_hold",    1, 0, 2'b00, 8'h00, 8'h00, 8'h0C, 0, 8'd0, 2'd0);
    add("sr_illegal", 1, 0, 2'b00, 8'h01, 8'h01, SET_DOM ? 8'h0D : 8'h0C, 1, 8'd1, 2'd1);
    add("ill_pulse",  1, 0, 2'b00, 8'h00, 8'h00, SET_DOM ? 8'h0D : 8'h0C, 0, 8'd1, 2'd1);
    add("jk_toggle",  1, 0, 2'b01, 8'hFF, 8'hFF, SET_DOM ? 8'hF2 : 8'hF3, 0, 8'd1, 2'd1);
    add("jk_set_rst", 1, 0, 2'b01, 8'h30, 8'h03, SET_DOM ? 8'hF0 : 8'hF0, 0, 8'd1, 2'd1);
    add("t_toggle",   1, 0, 2'b10, 8'h0F, 8'hAA, 8'hFF, 0, 8'd1, 2'd1);
    add("d_load",     1, 0, 2'b11, 8'hA5, 8'hFF, 8'hA5, 0, 8'd1, 2'd1);
    add("sr_ill_hi",  1, 0, 2'b00, 8'h80, 8'h80, 8'hA5, 1, 8'd2, 2'd2);
    add("en_hold",    0, 0, 2'b11, 8'hFF, 8'h00, 8'hA5, 0, 8'd2, 2'd2);
    add("clr_prio",   1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 8'd0, 2'd0);
    add("sat_1",      1, 0, 2'b00, 8'h01, 8'h01, SET_DOM ? 8'h01 : 8'h00, 1, 8'd1, 2'd1);
    add("sat_2",      1, 0, 2'b00, 8'h01, 8'h01, SET_DOM ? 8'h01 : 8'h00, 1, 8'd2, 2'd2);
    add("sat_3",      1, 0, 2'b00, 8'h01, 8'h01, SET_DOM ? 8'h01 : 8'h00, 1, 8'd3, 2'd3);
    add("sat_4",      1, 0, 2'b00, 8'h01, 8'h01, SET_DOM ? 8'h01 : 8'h00, 1, 8'd4, 2'd3);
    add("multi_bit",  1, 0, 2'b00, 8'hFF, 8'hFF, SET_DOM ? 8'hFF : 8'h00, 1, 8'd5, 2'd3);
    add("en0_no_ill", 0, 0, 2'b00, 8'hFF, 8'hFF, SET_DOM ? 8'hFF : 8'h00, 0, 8'd5, 2'd3);
    add("d_prereset", 1, 0, 2'b11, 8'hA5, 8'h00, 8'hA5, 0, 8'd5, 2'd3);

    rst_n      = 1'b0;
    bus_a.en   = 1'b0;
    bus_a.clr  = 1'b0;
    bus_a.mode = 2'b00;
    bus_a.S    = 8'h00;
    bus_a.R    = 8'h00;

    // Reset state, held across a clock edge.
    @(negedge clk);
    @(negedge clk);
    check_state("reset", 8'h00, 1'b0, 8'd0, 2'd0);
    rst_n = 1'b1;

    // Table: drive on falling edge, check after the following rising edge.
    foreach (vecs[i]) begin
      bus_a.en   = vecs[i].en;
      bus_a.clr  = vecs[i].clr;
      bus_a.mode = vecs[i].mode;
      bus_a.S    = vecs[i].s;
      bus_a.R    = vecs[i].r;
      @(negedge clk);
      check_state(vecs[i].name, vecs[i].exp_q, vecs[i].exp_ill,
                  vecs[i].exp_cnt, vecs[i].exp_cnt2);
    end

    // Async reset mid-cycle with Q=A5 and nonzero counters: clears without a clock edge.
    bus_a.en   = 1'b1;
    bus_a.mode = 2'b00;
    bus_a.S    = 8'h02;
    bus_a.R    = 8'h02;
    @(posedge clk);
    #2;
    check_state("pre_async", 8'hA5, 1'b1, 8'd6, 2'd3);
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 8'h00, 1'b0, 8'd0, 2'd0);
    @(posedge clk);
    #1;
    check_state("rst_held", 8'h00, 1'b0, 8'd0, 2'd0);

    // Synchronous release: first rising edge with rst_n=1 performs the update.
    @(negedge clk);
    rst_n      = 1'b1;
    bus_a.mode = 2'b11;
    bus_a.S    = 8'h3C;
    @(negedge clk);
    check_state("post_rel", 8'h3C, 1'b0, 8'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dff_to_sr_bank

// File: doc/dff_to_sr_bank.md
Name: dff_to_sr_bank

Overview:
- Bank of WIDTH storage bits. Each bit is a plain D flip-flop with next-state logic in front of it, so the bank behaves as an SR flip-flop.
- JK, T and pass-through D behaviour are selectable at run time.
- Adds illegal-input detection (S=R=1 in SR mode) and a saturating error counter.
- Sits alongside the existing SR-to-D conversion blocks as the inverse conversion: D storage presented as SR storage.

Parameters:
- WIDTH, 8, number of independent storage bits.
- ERR_CNT_W, 8, width of the saturating illegal-input counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  update enable; when 0 all bits hold.
- clr  input  1  synchronous clear of Q, illegal flag and err_count; has priority over en.
- mode  input  2  per-bank behaviour select: 00 SR, 01 JK, 10 T, 11 D.
- S  input  WIDTH  set input (J in JK mode, T in T mode, D in D mode).
- R  input  WIDTH  reset input (K in JK mode, ignored in T and D modes).
- Q  output  WIDTH  registered state.
- Qb  output  WIDTH  bitwise inverse of Q, always ~Q (never equal to Q).
- illegal  output  1  registered; 1 for one cycle after an update edge where any bit had S=R=1 in SR mode.
- err_count  output  ERR_CNT_W  saturating count of illegal update edges.

Behaviour:
- Reset (rst_n=0, asynchronous): Q=0, Qb=all ones, illegal=0, err_count=0.
- Release of rst_n is synchronous to clk. The first update happens on the first rising edge with rst_n=1.
- Latency: all outputs change on the rising edge that samples the inputs. There is no combinational path from S/R/mode to Q.
- Priority per edge: rst_n, then clr, then en=0 (hold, illegal cleared to 0, err_count held), then mode logic.
- SR mode, per bit:
  - S=0,R=0 hold.
  - S=1,R=0 set.
  - S=0,R=1 reset.
  - S=1,R=1 illegal: Q bit holds; illegal asserts next cycle.
- JK mode, per bit: 00 hold, 10 set, 01 reset, 11 toggle. Never illegal.
- T mode: Q bit toggles where S=1 and holds otherwise. R is ignored.
- D mode: Q is loaded with S. R is ignored.
- illegal: set to 1 on an enabled SR-mode edge where |(S&R) is true; 0 on every other edge. It is a one-cycle pulse unless the condition repeats.
- err_count:
  - Increments by 1 on each edge where illegal is being set, regardless of how many bits were illegal.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
- Mode change: takes effect on the same edge it is sampled. No pipeline state carries across modes.
- Simultaneous clr and illegal inputs: clr wins. Q=0, illegal=0, err_count=0.
- rst_n asserted mid-operation: all state clears immediately, independent of clk.

Optional Feature:
- Macro: SR_SET_DOMINANT_EN.
- Defined: in SR mode, S=R=1 sets the Q bit to 1 (set-dominant). illegal and err_count still update as specified.
- Undefined: S=R=1 holds the Q bit (default behaviour above).

Decomposition:
- Shared package dff_to_sr_pkg:
  - mode enum: MODE_SR=2'b00, MODE_JK=2'b01, MODE_T=2'b10, MODE_D=2'b11.
  - Default widths as localparams.
- One natural sub-module: d2sr_bit_cell.
  - Inputs: S bit, R bit, mode, en, clr, clk, rst_n.
  - Outputs: Q bit and a per-bit illegal_hit.
  - Contains the next-state mux and the D flop.
  - Instantiated WIDTH times via generate.
- Top level ORs the illegal_hit signals and owns the illegal flag and the counter.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with Q=8'hA5 → Q=8'h00, Qb=8'hFF, illegal=0, err_count=0 immediately, without waiting for a clock edge.
- SR basic: mode=00, S=8'h0F, R=8'h00 → Q=8'h0F; then S=0, R=8'h03 → Q=8'h0C; then S=R=0 → Q stays 8'h0C.
- SR illegal: Q=8'h0C, S=8'h01, R=8'h01 → Q=8'h0C, illegal=1 for exactly one cycle, err_count=1.
  - With SR_SET_DOMINANT_EN defined → Q=8'h0D, same illegal and err_count response.
- JK/T: mode=01, S=R=8'hFF from Q=8'h0C → Q=8'hF3; mode=10, S=8'h0F → Q=8'hFC; illegal stays 0 throughout.
- Saturation: ERR_CNT_W=2, four consecutive illegal SR edges → err_count sequence 1, 2, 3, 3.
- Priority: en=0 with S=8'hFF, mode=11 → Q holds; next edge en=1, clr=1, S=R=8'hFF, mode=00 → Q=0, illegal=0, err_count=0.
